// File: rtl/comp_nbs_pipe.sv
// rtl/comp_nbs_pipe.sv - segmented MSB-first pipelined signed/unsigned comparator with valid/ready
// Optional result counters enabled by defining CMP_STATS_EN.
`timescale 1ns/1ps
module comp_nbs_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             neq,
  output logic             grt,
  output logic             lss,
  output logic [TAG_W-1:0] out_tag
`ifdef CMP_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_grt,
  output logic [CNT_W-1:0] cnt_lss
`endif
);

  localparam int NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_width
    $error("comp_nbs_pipe: WIDTH must be a non-zero multiple of SEG_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("comp_nbs_pipe: CNT_W must be at least 1");
  end

  logic [NSEG-1:0]  v_q, v_d, gt_q, gt_d, lt_q, lt_d;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [TAG_W-1:0] tag_q [NSEG];
  logic [TAG_W-1:0] tag_d [NSEG];
  logic             has_q, has_d;
  logic             adv;

  logic             cv, csg;
  logic [1:0]       cdec, res;
  logic [WIDTH-1:0] ca, cb;
  logic [TAG_W-1:0] ct;

  // A decided {gt,lt} pair passes through untouched; only stage 0 may compare signed.
  function automatic logic [1:0] seg_step(input logic [SEG_W-1:0] sa, input logic [SEG_W-1:0] sb,
                                          input logic sgn, input logic [1:0] dec);
    if (dec != 2'b00) return dec;
    if (sgn) return {$signed(sa) > $signed(sb), $signed(sa) < $signed(sb)};
    return {sa > sb, sa < sb};
  endfunction

  always_comb begin
    adv = !v_q[NSEG-1] || out_ready;
    for (int k = 0; k < NSEG; k++) begin
      int p;
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        cv = in_valid; cdec = 2'b00; ca = op1; cb = op2; ct = in_tag; csg = sign;
      end else begin
        cv = v_q[p]; cdec = {gt_q[p], lt_q[p]}; ca = a_q[p]; cb = b_q[p]; ct = tag_q[p]; csg = 1'b0;
      end
      res    = seg_step(ca[WIDTH-1 -: SEG_W], cb[WIDTH-1 -: SEG_W], csg, cdec);
      v_d[k] = cv;
      a_d[k] = ca << SEG_W;
      b_d[k] = cb << SEG_W;
      // The output stage keeps the last reported result across bubbles.
      if (k == NSEG - 1 && !cv) begin
        gt_d[k] = gt_q[k]; lt_d[k] = lt_q[k]; tag_d[k] = tag_q[k];
      end else begin
        gt_d[k] = res[1]; lt_d[k] = res[0]; tag_d[k] = ct;
      end
    end
    has_d = has_q | v_d[NSEG-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q   <= '0;
      gt_q  <= '0;
      lt_q  <= '0;
      has_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0; b_q[k] <= '0; tag_q[k] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
      has_q <= has_d;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k]; b_q[k] <= b_d[k]; tag_q[k] <= tag_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[NSEG-1];
  assign grt       = gt_q[NSEG-1];
  assign lss       = lt_q[NSEG-1];
  assign eq        = has_q & ~gt_q[NSEG-1] & ~lt_q[NSEG-1];
  assign neq       = has_q & (gt_q[NSEG-1] | lt_q[NSEG-1]);
  assign out_tag   = tag_q[NSEG-1];

`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d, cnt_grt_q, cnt_grt_d, cnt_lss_q, cnt_lss_d;
  logic             xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_comb begin
    xfer      = out_valid & out_ready;
    cnt_eq_d  = cnt_eq_q;
    cnt_grt_d = cnt_grt_q;
    cnt_lss_d = cnt_lss_q;
    if (stat_clr) begin
      cnt_eq_d = '0; cnt_grt_d = '0; cnt_lss_d = '0;
    end else if (xfer) begin
      if (eq)  cnt_eq_d  = sat_inc(cnt_eq_q);
      if (grt) cnt_grt_d = sat_inc(cnt_grt_q);
      if (lss) cnt_lss_d = sat_inc(cnt_lss_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_eq_q <= '0; cnt_grt_q <= '0; cnt_lss_q <= '0;
    end else begin
      cnt_eq_q <= cnt_eq_d; cnt_grt_q <= cnt_grt_d; cnt_lss_q <= cnt_lss_d;
    end
  end

  assign cnt_eq  = cnt_eq_q;
  assign cnt_grt = cnt_grt_q;
  assign cnt_lss = cnt_lss_q;
`endif

endmodule

// File: tb/tb_comp_nbs_pipe.sv
// tb/tb_comp_nbs_pipe.sv - self-checking bench for comp_nbs_pipe (32/8, 16/16 and 64/8 builds)
`timescale 1ns/1ps
module tb_comp_nbs_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, sign, out_ready;
  logic [63:0] opa, opb;
  logic [3:0]  in_tag;

  logic       rdy0, ov0, eq0, neq0, gt0, lt0;
  logic       rdy1, ov1, eq1, neq1, gt1, lt1;
  logic       rdy2, ov2, eq2, neq2, gt2, lt2;
  logic [3:0] tag0, tag1, tag2;
`ifdef CMP_STATS_EN
  logic       stat_clr;
  logic [3:0] ce0, cg0, cl0, ce1, cg1, cl1, ce2, cg2, cl2;
`endif

  comp_nbs_pipe #(.WIDTH(32), .SEG_W(8), .TAG_W(4), .CNT_W(4)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy0), .sign(sign),
    .op1(opa[31:0]), .op2(opb[31:0]), .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready),
    .eq(eq0), .neq(neq0), .grt(gt0), .lss(lt0), .out_tag(tag0)
`ifdef CMP_STATS_EN
    , .stat_clr(stat_clr), .cnt_eq(ce0), .cnt_grt(cg0), .cnt_lss(cl0)
`endif
  );

  comp_nbs_pipe #(.WIDTH(16), .SEG_W(16), .TAG_W(4), .CNT_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy1), .sign(sign),
    .op1(opa[15:0]), .op2(opb[15:0]), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
    .eq(eq1), .neq(neq1), .grt(gt1), .lss(lt1), .out_tag(tag1)
`ifdef CMP_STATS_EN
    , .stat_clr(stat_clr), .cnt_eq(ce1), .cnt_grt(cg1), .cnt_lss(cl1)
`endif
  );

  comp_nbs_pipe #(.WIDTH(64), .SEG_W(8), .TAG_W(4), .CNT_W(4)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy2), .sign(sign),
    .op1(opa), .op2(opb), .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready),
    .eq(eq2), .neq(neq2), .grt(gt2), .lss(lt2), .out_tag(tag2)
`ifdef CMP_STATS_EN
    , .stat_clr(stat_clr), .cnt_eq(ce2), .cnt_grt(cg2), .cnt_lss(cl2)
`endif
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int nres [3] = '{0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Whole-operand reference: {eq, gt, lt} for a w-bit compare.
  function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input int w);
    logic [63:0]        ua, ub;
    logic signed [63:0] sa, sb;
    ua = (a << (64 - w)) >> (64 - w);
    ub = (b << (64 - w)) >> (64 - w);
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    if (s) return {sa == sb, sa > sb, sa < sb};
    return {ua == ub, ua > ub, ua < ub};
  endfunction

  typedef struct {
    logic [2:0] f;
    logic [3:0] tag;
  } exp_t;
  exp_t q0[$], q1[$], q2[$];

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) q0.delete();
    else begin
      if (ov0 && out_ready) begin
        if (q0.size() == 0) check("sb0_unexpected_result", ov0, 1'b0);
        else begin
          e = q0.pop_front(); nres[0]++;
          check("sb0_result", {eq0, gt0, lt0, neq0, tag0}, {e.f, ~e.f[2], e.tag});
        end
      end
      if (in_valid && rdy0) q0.push_back('{ref_cmp(opa, opb, sign, 32), in_tag});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) q1.delete();
    else begin
      if (ov1 && out_ready) begin
        if (q1.size() == 0) check("sb1_unexpected_result", ov1, 1'b0);
        else begin
          e = q1.pop_front(); nres[1]++;
          check("sb1_result", {eq1, gt1, lt1, neq1, tag1}, {e.f, ~e.f[2], e.tag});
        end
      end
      if (in_valid && rdy1) q1.push_back('{ref_cmp(opa, opb, sign, 16), in_tag});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) q2.delete();
    else begin
      if (ov2 && out_ready) begin
        if (q2.size() == 0) check("sb2_unexpected_result", ov2, 1'b0);
        else begin
          e = q2.pop_front(); nres[2]++;
          check("sb2_result", {eq2, gt2, lt2, neq2, tag2}, {e.f, ~e.f[2], e.tag});
        end
      end
      if (in_valid && rdy2) q2.push_back('{ref_cmp(opa, opb, sign, 64), in_tag});
    end
  end

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
  } vec_t;
  vec_t vt [10];

  // One compare through dut0 with a drained pipe: out_valid must rise exactly 4 cycles later.
  task automatic run_vec(input vec_t v, input logic [3:0] t, input string nm);
    @(posedge clk); #1;
    in_valid = 1'b1; sign = v.s; in_tag = t;
    opa = {$urandom(), v.a}; opb = {$urandom(), v.b};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({nm, "_early"}, ov0, 1'b0);
    @(negedge clk);
    check({nm, "_valid"}, ov0, 1'b1);
    check({nm, "_flags"}, {eq0, neq0, gt0, lt0, tag0}, {v.f[2], ~v.f[2], v.f[1], v.f[0], t});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    vt[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b010};
    vt[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b001};
    vt[2] = '{1'b0, 32'h1234_5678, 32'h1234_5678, 3'b100};
    vt[3] = '{1'b1, 32'h8000_0000, 32'h8000_0001, 3'b001};
    vt[4] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b010};
    vt[5] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b001};
    vt[6] = '{1'b1, 32'h7F00_0000, 32'h80FF_FFFF, 3'b010};
    vt[7] = '{1'b0, 32'h0000_0100, 32'h0000_00FF, 3'b010};
    vt[8] = '{1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 3'b001};
    vt[9] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 3'b100};

    resetn = 1'b0; in_valid = 1'b0; sign = 1'b0; out_ready = 1'b1;
    opa = '0; opb = '0; in_tag = '0;
`ifdef CMP_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", ov0, 1'b0);
    check("reset_flags", {eq0, neq0, gt0, lt0, tag0}, 8'h00);
    check("reset_in_ready", rdy0, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("release_flags", {ov0, eq0, neq0, gt0, lt0}, 5'b0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], 4'(i + 1), $sformatf("vec%0d", i));

    // Back-to-back tags 1..4 with the consumer stalled once the first result shows.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sign = vt[i].s; in_tag = 4'(i + 1);
      opa = {32'h0, vt[i].a}; opb = {32'h0, vt[i].b};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_hold", i), {ov0, rdy0, tag0, gt0}, {1'b1, 1'b0, 4'd1, 1'b1});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stall_order%0d", i), {ov0, tag0}, {1'b1, 4'(i + 1)});
    end

    // Asynchronous reset while a result is held at the output.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; sign = 1'b0; in_tag = 4'd9;
    opa = 64'h5; opb = 64'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held_before_reset", {ov0, gt0}, 2'b11);
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", {ov0, eq0, neq0, gt0, lt0, tag0}, 9'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1; out_ready = 1'b1;

    // Reset pulse two cycles after acceptance discards the in-flight compare.
    @(posedge clk); #1;
    in_valid = 1'b1; sign = 1'b0; in_tag = 4'd7; opa = 64'hFF; opb = 64'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov0) cnt++;
    end
    check("discarded_after_reset", cnt, 0);
    run_vec(vt[3], 4'd11, "post_reset");

`ifdef CMP_STATS_EN
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; sign = 1'($urandom()); in_tag = 4'(i);
      opa = {$urandom(), $urandom()}; opb = opa;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("stats_eq_saturated", ce0, 4'd15);
    check("stats_other_zero", {cg0, cl0}, 8'h00);
    @(posedge clk); #1;
    in_valid = 1'b1; opa = 64'h42; opb = 64'h42; in_tag = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stats_clr_setup", {ov0, eq0}, 2'b11);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("stats_clr_wins", ce0, 4'd0);
`endif

    // Random traffic with random back-pressure, checked by the scoreboards.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sign      = 1'($urandom());
      in_tag    = 4'($urandom());
      opa       = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: opb = {$urandom(), $urandom()};
        1: opb = opa;
        2: opb = opa ^ (64'h1 << $urandom_range(0, 63));
        default: opb = opa ^ (64'h1 << $urandom_range(0, 15));
      endcase
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain_q0_empty", q0.size(), 0);
    check("drain_q1_empty", q1.size(), 0);
    check("drain_q2_empty", q2.size(), 0);
    check("activity_dut0", nres[0] > 500, 1'b1);
    check("activity_dut1", nres[1] > 500, 1'b1);
    check("activity_dut2", nres[2] > 500, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
